// File: rtl/updown_pkg.sv
// updown_pkg: shared definitions for the up/down sweep controller and its
// shadow model.
//   ST_*        - 2-bit controller state encodings
//   CNT_BITS    - width of the controlled counter (fixed at 3)
//   CNT_MAX     - terminal value of the counter when counting up
//   tc_expected - terminal-count value the counter must present for a given
//                 direction and q; shared with the counter's own checker
package updown_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned CNT_BITS = 3;
    localparam logic [CNT_BITS-1:0] CNT_MAX = 3'd7;

    // tc is high at 7 when counting up and at 0 when counting down.
    function automatic logic tc_expected(input logic dir, input logic [CNT_BITS-1:0] q);
        return dir ? (q == CNT_MAX) : (q == '0);
    endfunction

endpackage

// File: rtl/updown_shadow_model.sv
// updown_shadow_model: shadow copy of the 3-bit up/down counter plus the
// q/tc consistency comparison.
//   clk, clr  - clock and synchronous active-high reset
//   load      - zero the shadow (run start)
//   active    - counter is enabled this cycle; shadow steps and checks run
//   dir       - 1 = up, 0 = down
//   q_in      - counter q
//   tc_in     - counter terminal count
//   mismatch  - combinational: active and (q differs from shadow or tc wrong)
module updown_shadow_model
    import updown_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             active,
    input  logic             dir,
    input  logic [CNT_W-1:0] q_in,
    input  logic             tc_in,
    output logic             mismatch
);

    logic [CNT_W-1:0] shadow_d, shadow_q;

    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = '0;
        end else if (active) begin
            shadow_d = dir ? shadow_q + 1'b1 : shadow_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        mismatch = active && ((q_in != shadow_q) || (tc_in != tc_expected(dir, q_in)));
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives a 3-bit up/down counter through N full wraps up,
// then N full wraps down, then parks it at 000, checking it against a shadow.
//   clk, clr    - clock and synchronous active-high reset
//   start       - run request (sampled in IDLE only)
//   abort       - stop an active run (sampled in UP/DOWN only)
//   num_sweeps  - wraps per direction, captured when start is accepted
//   q_in, tc_in - counter outputs
//   dir_out     - counter Dir (1 = up); clrbar_out - counter clrbar (0 = clear)
//   busy        - high in UP and DOWN; done - one-cycle completion pulse
//   err         - sticky consistency error; wraps - wraps counted this phase
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int SWEEP_W = 4,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               abort,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [CNT_W-1:0]   q_in,
    input  logic               tc_in,
    output logic               dir_out,
    output logic               clrbar_out,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] wraps
);

    logic [1:0]         state_d, state_q;
    logic [SWEEP_W-1:0] n_d, n_q;
    logic [SWEEP_W-1:0] wraps_d, wraps_q;
    logic               first_dn_d, first_dn_q;
    logic               err_d, err_q;

    logic               mismatch;
    logic               load;
    logic [SWEEP_W:0]   wraps_inc;
    logic               last_wrap;
    logic [SWEEP_W-1:0] wraps_sat;

    // Outputs are pure state decodes: no path from q_in/tc_in to the counter.
    always_comb begin
        busy       = (state_q == ST_UP) || (state_q == ST_DOWN);
        clrbar_out = busy;
        dir_out    = (state_q != ST_DOWN);
        done       = (state_q == ST_DONE);
        err        = err_q;
        wraps      = wraps_q;
    end

    assign load      = (state_q == ST_IDLE) && start;
    assign wraps_inc = {1'b0, wraps_q} + 1'b1;
    assign last_wrap = (wraps_inc == {1'b0, n_q});
    assign wraps_sat = (&wraps_q) ? wraps_q : wraps_inc[SWEEP_W-1:0];

    updown_shadow_model #(
        .CNT_W (CNT_W)
    ) u_shadow (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .active   (busy),
        .dir      (dir_out),
        .q_in     (q_in),
        .tc_in    (tc_in),
        .mismatch (mismatch)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wraps_d    = wraps_q;
        first_dn_d = first_dn_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    wraps_d = '0;
                    if (num_sweeps != '0) begin
                        n_d     = num_sweeps;
                        state_d = ST_UP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_UP: begin
                err_d = err_q | mismatch;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tc_in) begin
                    if (last_wrap) begin
                        wraps_d    = '0;
                        first_dn_d = 1'b1;
                        state_d    = ST_DOWN;
                    end else begin
                        wraps_d = wraps_sat;
                    end
                end
            end
            ST_DOWN: begin
                err_d      = err_q | mismatch;
                first_dn_d = 1'b0;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tc_in && !first_dn_q) begin
                    // The tc seen on DOWN entry is the 7->0 wrap just left behind.
                    if (last_wrap) begin
                        wraps_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        wraps_d = wraps_sat;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            wraps_q    <= '0;
            first_dn_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            wraps_q    <= wraps_d;
            first_dn_q <= first_dn_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a behavioural 3-bit up/down counter closes the
// loop; per-cycle expectations come from closed-form run timing.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       clr, start, abort;
    logic [3:0] num_sweeps;
    logic [2:0] q_in;
    logic       tc_in;
    logic       dir_out, clrbar_out, busy, done, err;
    logic [3:0] wraps;

    logic [2:0] cnt = '0;
    logic       glitch = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    updown_sweep_ctrl #(
        .SWEEP_W (4),
        .CNT_W   (3)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .abort      (abort),
        .num_sweeps (num_sweeps),
        .q_in       (q_in),
        .tc_in      (tc_in),
        .dir_out    (dir_out),
        .clrbar_out (clrbar_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wraps      (wraps)
    );

    // Controlled counter: synchronous clear via clrbar, up/down otherwise.
    always @(posedge clk) begin
        if (!clrbar_out) cnt <= 3'd0;
        else if (dir_out) cnt <= cnt + 3'd1;
        else cnt <= cnt - 3'd1;
    end
    assign q_in  = glitch ? 3'd5 : cnt;
    assign tc_in = dir_out ? (cnt == 3'd7) : (cnt == 3'd0);

    typedef struct {
        int n;
        int glitch_k;     // cycle in which q_in is forced to 5 (0 = none)
        int abort_dn;     // DOWN cycle index in which abort is held (0 = none)
        int start_abort;  // abort asserted together with start
        int extra_k;      // cycle with a spurious start pulse (0 = none)
        int exp_busy;
        int exp_done;
        int exp_err;
    } vec_t;

    typedef struct {
        logic       busy;
        logic       done;
        logic       dir;
        logic       clrbar;
        logic       err;
        logic       chk_wraps;
        logic [3:0] wraps;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t expect_at(input vec_t v, input int k);
        exp_t e;
        int   j;
        e.busy = 0; e.done = 0; e.dir = 1; e.clrbar = 0; e.chk_wraps = 0; e.wraps = 0;
        e.err = (v.glitch_k != 0) && (k > v.glitch_k);
        if (v.abort_dn != 0 && k > 8 * v.n + v.abort_dn) return e;
        if (v.n == 0) begin
            e.done = (k == 1);
            return e;
        end
        if (k <= 8 * v.n) begin
            e.busy = 1; e.clrbar = 1; e.chk_wraps = 1;
            e.wraps = 4'((k - 1) / 8);
        end else if (k <= 16 * v.n + 1) begin
            e.busy = 1; e.clrbar = 1; e.dir = 0; e.chk_wraps = 1;
            j = k - 8 * v.n - 1;
            e.wraps = (j == 0) ? 4'd0 : 4'((j - 1) / 8);
        end else if (k == 16 * v.n + 2) begin
            e.done = 1;
        end
        return e;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   last;
        int   busy_cnt = 0;
        int   done_cnt = 0;
        num_sweeps = 4'(v.n);
        start      = 1'b1;
        abort      = (v.start_abort != 0);
        last = (v.abort_dn != 0) ? 8 * v.n + v.abort_dn + 3 : 16 * v.n + 5;
        for (int k = 1; k <= last; k++) begin
            exp_q.push_back(expect_at(v, k));
            @(posedge clk);
            #1;
            start      = (k == v.extra_k);
            num_sweeps = start ? 4'd1 : 4'(v.n);
            abort      = (v.abort_dn != 0) && (k == 8 * v.n + v.abort_dn);
            glitch     = (k == v.glitch_k);
            e = exp_q.pop_front();
            check($sformatf("v%0d k%0d busy", idx, k), 32'(busy), 32'(e.busy));
            check($sformatf("v%0d k%0d done", idx, k), 32'(done), 32'(e.done));
            check($sformatf("v%0d k%0d dir", idx, k), 32'(dir_out), 32'(e.dir));
            check($sformatf("v%0d k%0d clrbar", idx, k), 32'(clrbar_out), 32'(e.clrbar));
            check($sformatf("v%0d k%0d err", idx, k), 32'(err), 32'(e.err));
            if (e.chk_wraps) check($sformatf("v%0d k%0d wraps", idx, k), 32'(wraps), 32'(e.wraps));
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        start = 1'b0; abort = 1'b0; glitch = 1'b0;
        check($sformatf("v%0d busy_cycles", idx), 32'(busy_cnt), 32'(v.exp_busy));
        check($sformatf("v%0d done_pulses", idx), 32'(done_cnt), 32'(v.exp_done));
        check($sformatf("v%0d final_err", idx), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d counter_parked", idx), 32'(cnt), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " dir"}, 32'(dir_out), 32'd1);
        check({tag, " clrbar"}, 32'(clrbar_out), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " wraps"}, 32'(wraps), 32'd0);
    endtask

    initial begin
        //          n  glitch abort sa extra busy done err
        tbl[0] = '{1, 0, 0, 0, 18, 17, 1, 0};  // spurious start in DONE
        tbl[1] = '{3, 0, 0, 0, 4, 49, 1, 0};   // spurious start mid-UP
        tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[3] = '{1, 5, 0, 0, 0, 17, 1, 1};   // q forced 5 while shadow is 4
        tbl[4] = '{2, 5, 3, 0, 0, 19, 0, 1};   // abort in DOWN cycle 3, err kept
        tbl[5] = '{2, 0, 0, 0, 0, 33, 1, 0};
        tbl[6] = '{1, 0, 0, 1, 0, 17, 1, 0};   // start beats abort in IDLE

        clr = 1'b1; start = 1'b0; abort = 1'b0; num_sweeps = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], i);
        end

        // Reset mid-UP with a simultaneous start: reset wins, start is lost.
        num_sweeps = 4'd2;
        start      = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            start  = 1'b0;
            glitch = (k == 5);
        end
        check("midup busy", 32'(busy), 32'd1);
        check("midup wraps", 32'(wraps), 32'd1);
        check("midup err", 32'(err), 32'd1);
        clr        = 1'b1;
        start      = 1'b1;
        num_sweeps = 4'd1;
        @(posedge clk);
        #1;
        check_reset_outputs("midclr");
        clr   = 1'b0;
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("postclr k%0d busy", k), 32'(busy), 32'd0);
            check($sformatf("postclr k%0d done", k), 32'(done), 32'd0);
        end
        check("postclr counter", 32'(cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
